// File: rtl/arbiter_game_pkg.sv
// Shared types and constants for the multi-player reaction-game arbiter.
// Holds the FSM state enum, the per-state control-output encodings
// {cd_rst, w_rst, leds_rst, leds_sel} and the maximum supported player count.
package arbiter_game_pkg;

  localparam int MAX_PLAYERS = 8;

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_WAITING   = 3'd2,
    ST_GNT       = 3'd3,
    ST_WIN       = 3'd4,
    ST_END       = 3'd5
  } state_t;

  // Bit order: {cd_rst, w_rst, leds_rst, leds_sel}
  localparam logic [3:0] CTRL_RST       = 4'b1110;
  localparam logic [3:0] CTRL_COUNTDOWN = 4'b0100;
  localparam logic [3:0] CTRL_WAITING   = 4'b1110;
  localparam logic [3:0] CTRL_GNT       = 4'b1001;
  localparam logic [3:0] CTRL_WIN       = 4'b1001;
  localparam logic [3:0] CTRL_END       = 4'b1110;

  function automatic logic [3:0] ctrl_decode(input state_t s);
    logic [3:0] c;
    case (s)
      ST_RST:       c = CTRL_RST;
      ST_COUNTDOWN: c = CTRL_COUNTDOWN;
      ST_WAITING:   c = CTRL_WAITING;
      ST_GNT:       c = CTRL_GNT;
      ST_WIN:       c = CTRL_WIN;
      ST_END:       c = CTRL_END;
      default:      c = CTRL_RST;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/arbiter_game_req_encoder.sv
// Purely combinational encoder for the eligible-masked player requests.
// Ports: req (masked request vector) -> one (exactly one bit set),
//        onehot (req when exactly one bit set, else 0), idx (binary index of that bit).
module arbiter_game_req_encoder #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic             one,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    one    = (req != '0) && ((req & (req - N'(1))) == '0);
    onehot = one ? req : '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/arbiter_game_fsm_n.sv
// Moore FSM arbitrating a first-press reaction game among N_PLAYERS players,
// with per-player saturating scores and optional false-start detection.
// Ports: clk, rst_in_n (async active-low); req, cd_done, w_done in;
//        gnt_out, winner_idx_out, winner_vld_out, cd_rst_out, w_rst_out,
//        leds_rst_out, leds_sel_out, score_out (packed), foul_out out.
// Build option: define ARBITER_GAME_FALSE_START_EN to flag presses during the
// countdown as fouls and exclude fouled players from the following race.
module arbiter_game_fsm_n
  import arbiter_game_pkg::*;
#(
  parameter int N_PLAYERS = 4,
  parameter int SCORE_W   = 4
) (
  input  logic                           clk,
  input  logic                           rst_in_n,
  input  logic [N_PLAYERS-1:0]           req,
  input  logic                           cd_done,
  input  logic                           w_done,
  output logic [N_PLAYERS-1:0]           gnt_out,
  output logic [$clog2(N_PLAYERS)-1:0]   winner_idx_out,
  output logic                           winner_vld_out,
  output logic                           cd_rst_out,
  output logic                           w_rst_out,
  output logic                           leds_rst_out,
  output logic                           leds_sel_out,
  output logic [N_PLAYERS*SCORE_W-1:0]   score_out,
  output logic [N_PLAYERS-1:0]           foul_out
);

  localparam int IDX_W = $clog2(N_PLAYERS);

  state_t               state, state_nxt;
  logic [N_PLAYERS-1:0] foul;
  logic [N_PLAYERS-1:0] elig;
  logic                 all_fouled;
  logic                 enc_one;
  logic [N_PLAYERS-1:0] enc_onehot;
  logic [IDX_W-1:0]     enc_idx;
  logic [N_PLAYERS-1:0] gnt;
  logic [IDX_W-1:0]     winner_idx;
  logic                 winner_vld;
  logic [SCORE_W-1:0]   score [N_PLAYERS];
  logic                 winner_released;

  // Only the winner's button matters once granted; other presses are ignored.
  assign winner_released = ((req & gnt) == '0);

`ifdef ARBITER_GAME_FALSE_START_EN
  logic [N_PLAYERS-1:0] foul_q;

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      foul_q <= '0;
    end else if (state == ST_COUNTDOWN) begin
      foul_q <= foul_q | req;
    end else if (state == ST_END && req == '0) begin
      foul_q <= '0;
    end
  end

  assign foul       = foul_q;
  assign elig       = req & ~foul_q;
  // Includes presses on the cd_done edge itself, which also count as fouls.
  assign all_fouled = &(foul_q | req);
`else
  assign foul       = '0;
  assign elig       = req;
  assign all_fouled = 1'b0;
`endif

  arbiter_game_req_encoder #(
    .N     (N_PLAYERS),
    .IDX_W (IDX_W)
  ) u_enc (
    .req    (elig),
    .one    (enc_one),
    .onehot (enc_onehot),
    .idx    (enc_idx)
  );

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) state <= ST_RST;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:       state_nxt = ST_COUNTDOWN;
      ST_COUNTDOWN: if (cd_done) state_nxt = all_fouled ? ST_END : ST_WAITING;
      ST_WAITING:   if (enc_one) state_nxt = ST_GNT;
      ST_GNT:       if (winner_released) state_nxt = ST_WIN;
      ST_WIN:       if (w_done) state_nxt = ST_END;
      ST_END:       if (req == '0) state_nxt = ST_COUNTDOWN;
      default:      state_nxt = ST_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      gnt        <= '0;
      winner_idx <= '0;
      winner_vld <= 1'b0;
      for (int i = 0; i < N_PLAYERS; i++) score[i] <= '0;
    end else begin
      if (state == ST_WAITING && enc_one) begin
        gnt        <= enc_onehot;
        winner_idx <= enc_idx;
        winner_vld <= 1'b1;
      end
      if (state == ST_GNT && winner_released) begin
        for (int i = 0; i < N_PLAYERS; i++) begin
          if (gnt[i] && score[i] != '1) score[i] <= score[i] + 1'b1;
        end
      end
      if (state == ST_WIN && w_done) gnt <= '0;
      if (state == ST_END && req == '0) winner_vld <= 1'b0;
    end
  end

  assign {cd_rst_out, w_rst_out, leds_rst_out, leds_sel_out} = ctrl_decode(state);
  assign gnt_out        = gnt;
  assign winner_idx_out = winner_idx;
  assign winner_vld_out = winner_vld;
  assign foul_out       = foul;

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_score
    assign score_out[g*SCORE_W +: SCORE_W] = score[g];
  end

endmodule

// File: tb/tb_arbiter_game_fsm_n.sv
// Self-checking bench for arbiter_game_fsm_n with 4 players and 4-bit scores.
// A round-phase model predicts every output each cycle; directed literals pin key points.
module tb_arbiter_game_fsm_n;

  localparam int N    = 4;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  localparam int P_IDLE = 0;
  localparam int P_CD   = 1;
  localparam int P_WAIT = 2;
  localparam int P_HOLD = 3;
  localparam int P_WIN  = 4;
  localparam int P_END  = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          cd_done;
  logic          w_done;
  logic [N-1:0]  gnt_out;
  logic [1:0]    winner_idx_out;
  logic          winner_vld_out;
  logic          cd_rst_out, w_rst_out, leds_rst_out, leds_sel_out;
  logic [N*SW-1:0] score_out;
  logic [N-1:0]  foul_out;
  logic [3:0]    ctrl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arbiter_game_fsm_n #(.N_PLAYERS(N), .SCORE_W(SW)) dut (
    .clk            (clk),
    .rst_in_n       (rst_n),
    .req            (req),
    .cd_done        (cd_done),
    .w_done         (w_done),
    .gnt_out        (gnt_out),
    .winner_idx_out (winner_idx_out),
    .winner_vld_out (winner_vld_out),
    .cd_rst_out     (cd_rst_out),
    .w_rst_out      (w_rst_out),
    .leds_rst_out   (leds_rst_out),
    .leds_sel_out   (leds_sel_out),
    .score_out      (score_out),
    .foul_out       (foul_out)
  );

  assign ctrl = {cd_rst_out, w_rst_out, leds_rst_out, leds_sel_out};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       m_phase = P_IDLE;
  int       m_winner = 0;
  bit       m_vld = 0;
  int       m_score [N];
  bit [N-1:0] m_foul = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  <= P_IDLE;
      m_winner <= 0;
      m_vld    <= 0;
      m_foul   <= '0;
      for (int i = 0; i < N; i++) m_score[i] <= 0;
    end else begin
      case (m_phase)
        P_IDLE: m_phase <= P_CD;
        P_CD: begin
`ifdef ARBITER_GAME_FALSE_START_EN
          m_foul <= m_foul | req;
          if (cd_done) m_phase <= (((m_foul | req) == {N{1'b1}}) ? P_END : P_WAIT);
`else
          if (cd_done) m_phase <= P_WAIT;
`endif
        end
        P_WAIT: begin
          if ($countones(req & ~m_foul) == 1) begin
            m_phase  <= P_HOLD;
            m_winner <= $clog2(req & ~m_foul);
            m_vld    <= 1;
          end
        end
        P_HOLD: begin
          if (!req[m_winner]) begin
            m_phase <= P_WIN;
            m_score[m_winner] <= (m_score[m_winner] >= SMAX) ? SMAX : m_score[m_winner] + 1;
          end
        end
        P_WIN: if (w_done) m_phase <= P_END;
        P_END: begin
          if (req == '0) begin
            m_phase <= P_CD;
            m_vld   <= 0;
            m_foul  <= '0;
          end
        end
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  function automatic logic [3:0] exp_ctrl(input int ph);
    if (ph == P_CD) return 4'b0100;
    if (ph == P_HOLD || ph == P_WIN) return 4'b1001;
    return 4'b1110;
  endfunction

  function automatic logic [N*SW-1:0] exp_scores();
    logic [N*SW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*SW +: SW] = SW'(m_score[i]);
    return v;
  endfunction

  always @(negedge clk) begin
    #1;
    check("m_ctrl", 64'(ctrl), 64'(exp_ctrl(m_phase)));
    check("m_gnt", 64'(gnt_out),
          64'((m_phase == P_HOLD || m_phase == P_WIN) ? (1 << m_winner) : 0));
    check("m_idx", 64'(winner_idx_out), 64'(m_winner));
    check("m_vld", 64'(winner_vld_out), 64'(m_vld));
    check("m_score", 64'(score_out), 64'(exp_scores()));
    check("m_foul", 64'(foul_out), 64'(m_foul));
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic play(input int p);
    cd_done = 1; cyc(); cd_done = 0;
    req = N'(1 << p); cyc();
    req = '0; cyc();
    w_done = 1; cyc(); w_done = 0;
    cyc();
  endtask

  initial begin
    rst_n = 1; req = '0; cd_done = 0; w_done = 0;
    #1 rst_n = 0;
    repeat (10) cyc();
    check("rst_ctrl", 64'(ctrl), 64'(4'b1110));
    check("rst_gnt", 64'(gnt_out), 64'(0));
    check("rst_score", 64'(score_out), 64'(0));

    rst_n = 1; cyc();
    check("cd_ctrl", 64'(ctrl), 64'(4'b0100));

    cd_done = 1; cyc(); cd_done = 0;
    req = 4'b0110; cyc();
    check("tie_gnt", 64'(gnt_out), 64'(0));
    check("tie_ctrl", 64'(ctrl), 64'(4'b1110));
    req = 4'b0100; cyc();
    check("gnt2_gnt", 64'(gnt_out), 64'(4'b0100));
    check("gnt2_idx", 64'(winner_idx_out), 64'(2));
    check("gnt2_ctrl", 64'(ctrl), 64'(4'b1001));
    req = '0; cyc();
    check("win_gnt", 64'(gnt_out), 64'(4'b0100));
    w_done = 1; cyc(); w_done = 0;
    check("end_score2", 64'(score_out[11:8]), 64'(1));
    check("end_vld", 64'(winner_vld_out), 64'(1));
    check("end_gnt", 64'(gnt_out), 64'(0));
    check("end_ctrl", 64'(ctrl), 64'(4'b1110));
    cyc();
    check("next_vld", 64'(winner_vld_out), 64'(0));
    check("next_ctrl", 64'(ctrl), 64'(4'b0100));

`ifndef ARBITER_GAME_FALSE_START_EN
    req = 4'b0100; cyc(); req = '0;
    check("cd_ignore_foul", 64'(foul_out), 64'(0));
    check("cd_ignore_ctrl", 64'(ctrl), 64'(4'b0100));
`endif

    // Player 1 wins while others press; END waits for all buttons released.
    cd_done = 1; cyc(); cd_done = 0;
    req = 4'b0010; cyc();
    req = 4'b1010; cyc();
    check("others_ign_ctrl", 64'(ctrl), 64'(4'b1001));
    check("others_ign_gnt", 64'(gnt_out), 64'(4'b0010));
    req = 4'b1000; cyc();
    w_done = 1; cyc(); w_done = 0;
    cyc();
    check("end_hold_ctrl", 64'(ctrl), 64'(4'b1110));
    check("end_hold_idx", 64'(winner_idx_out), 64'(1));
    check("end_hold_vld", 64'(winner_vld_out), 64'(1));
    req = '0; cyc();

    for (int r = 0; r < 17; r++) play(0);
    check("sat_score0", 64'(score_out[3:0]), 64'(15));
    check("keep_score1", 64'(score_out[7:4]), 64'(1));
    check("keep_score2", 64'(score_out[11:8]), 64'(1));

`ifdef ARBITER_GAME_FALSE_START_EN
    req = 4'b0010; cyc(); req = '0;
    check("foul1", 64'(foul_out), 64'(4'b0010));
    cd_done = 1; cyc(); cd_done = 0;
    req = 4'b0011; cyc();
    check("foul_gnt0", 64'(gnt_out), 64'(4'b0001));
    req = '0; cyc();
    w_done = 1; cyc(); w_done = 0;
    cyc();
    check("foul_clear", 64'(foul_out), 64'(0));
    req = 4'b1111; cd_done = 1; cyc(); cd_done = 0;
    check("allfoul_ctrl", 64'(ctrl), 64'(4'b1110));
    check("allfoul_vld", 64'(winner_vld_out), 64'(0));
    req = '0; cyc();
    check("allfoul_next", 64'(ctrl), 64'(4'b0100));
`endif

    // Reset mid-round while granted.
    cd_done = 1; cyc(); cd_done = 0;
    req = 4'b1000; cyc();
    check("pre_rst_ctrl", 64'(ctrl), 64'(4'b1001));
    rst_n = 0; #1;
    check("async_rst_ctrl", 64'(ctrl), 64'(4'b1110));
    check("async_rst_gnt", 64'(gnt_out), 64'(0));
    check("async_rst_score", 64'(score_out), 64'(0));
    check("async_rst_vld", 64'(winner_vld_out), 64'(0));
    req = '0;
    repeat (3) cyc();
    rst_n = 1; cyc();
    check("post_rst_ctrl", 64'(ctrl), 64'(4'b0100));
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
